// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one 32-bit ALU between two requesting ports. A three-state FSM
//   (IDLE -> EXEC -> RESP -> IDLE) picks one requester in IDLE and latches its
//   opcode and operands. The latched operation runs through the ALU during
//   EXEC. The result and flags are registered at the end of EXEC. The owner's
//   done pulse is raised during RESP. A request sampled in IDLE cycle N
//   completes with done in cycle N+2, so at most one operation runs every
//   three cycles.
//
//   Arbitration is round-robin. A lone request always wins. When both ports
//   request, the port that was not granted last wins. The last-grant pointer
//   resets so that FIRST_PRIO wins the first tie.
//
// Optional feature (macro ALU_ARB_ILLOP_EN):
//   When defined, a latched opcode in 4'hA..4'hF registers result=0 and all
//   arithmetic flags low, with illop=1. When undefined, illop is tied low and
//   illegal opcodes take the ALU default (result=0, zero=1).
//
// Parameters:
//   FIRST_PRIO  port (0 or 1) that wins the first simultaneous request
//
// Ports:
//   CLK              clock, all state on the rising edge
//   nRST             synchronous active-low reset
//   req0 / req1      level requests, held until the matching done is seen
//   aluop0 / aluop1  4-bit opcodes (0..9 = SLL SRL AND OR XOR NOR ADD SUB
//                    SLT SLTU)
//   porta0 / porta1  32-bit operand A
//   portb0 / portb1  32-bit operand B
//   done0 / done1    one-cycle completion pulse for the owning port
//   result           registered ALU result of the last completed op
//   negative         registered result[31]
//   overflow         registered carry/borrow (bit 32 of the 33-bit ADD/SUB)
//   zero             registered result == 0
//   illop            registered illegal-opcode flag
//   busy             high while in EXEC or RESP
// ============================================================================
module alu_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req0,
    input  logic [3:0]  aluop0,
    input  logic [31:0] porta0,
    input  logic [31:0] portb0,
    input  logic        req1,
    input  logic [3:0]  aluop1,
    input  logic [31:0] porta1,
    input  logic [31:0] portb1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        negative,
    output logic        overflow,
    output logic        zero,
    output logic        illop,
    output logic        busy
);

    // ALU opcode encoding
    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // A tie goes to the port that was not granted last. Starting the pointer
    // at the other port lets FIRST_PRIO win the first tie.
    localparam logic LAST_GRANT_RESET = (FIRST_PRIO == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant_valid;
    logic        grant_port;
    logic        last_grant;
    logic        owner;

    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic [32:0] sum_wide;
    logic [32:0] diff_wide;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_negative;
    logic        alu_zero;

`ifdef ALU_ARB_ILLOP_EN
    logic        op_illegal;
`endif

    // ------------------------------------------------------------------------
    // Round-robin winner selection.
    // The winner is only used while IDLE. It is evaluated every cycle so the
    // FSM and the operand latch see the same decision.
    // ------------------------------------------------------------------------
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else if (req1) begin
            grant_port = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register.
    // Reset from any state returns to IDLE. An in-flight operation is then
    // dropped without a done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic.
    // The sequence is fixed. Only IDLE waits, and it waits for a request.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs.
    // done goes only to the latched owner during RESP. busy covers the whole
    // time an operation is in flight.
    // ------------------------------------------------------------------------
    always_comb begin
        done0 = 1'b0;
        done1 = 1'b0;
        busy  = 1'b0;
        case (state)
            EXEC: begin
                busy = 1'b1;
            end
            RESP: begin
                busy  = 1'b1;
                done0 = ~owner;
                done1 = owner;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant capture.
    // The winner's opcode and operands are copied when IDLE accepts a
    // request. Later changes on the port inputs cannot reach the ALU.
    // The last-grant pointer moves at the same edge, on entry to EXEC.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_grant <= LAST_GRANT_RESET;
            owner      <= 1'b0;
            op_q       <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
        end else if ((state == IDLE) && grant_valid) begin
            last_grant <= grant_port;
            owner      <= grant_port;
            op_q       <= grant_port ? aluop1 : aluop0;
            a_q        <= grant_port ? porta1 : porta0;
            b_q        <= grant_port ? portb1 : portb0;
        end
    end

    // ------------------------------------------------------------------------
    // The single ALU shared by both ports. It is fed only from the latched
    // operands. Carry and borrow come from a 33-bit unsigned add/subtract.
    // Every other operation reports no overflow. Unknown opcodes fall to
    // result 0.
    // ------------------------------------------------------------------------
    assign sum_wide  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_wide = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (op_q)
            OP_SLL:  alu_result = a_q << b_q[4:0];
            OP_SRL:  alu_result = a_q >> b_q[4:0];
            OP_AND:  alu_result = a_q & b_q;
            OP_OR:   alu_result = a_q | b_q;
            OP_XOR:  alu_result = a_q ^ b_q;
            OP_NOR:  alu_result = ~(a_q | b_q);
            OP_ADD: begin
                alu_result   = sum_wide[31:0];
                alu_overflow = sum_wide[32];
            end
            OP_SUB: begin
                alu_result   = diff_wide[31:0];
                alu_overflow = diff_wide[32];
            end
            OP_SLT:  alu_result = {31'd0, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: alu_result = {31'd0, (a_q < b_q)};
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_negative = alu_result[31];
    assign alu_zero     = (alu_result == 32'd0);

`ifdef ALU_ARB_ILLOP_EN
    assign op_illegal = (op_q > OP_SLTU);

    // ------------------------------------------------------------------------
    // Result and flag registers, illegal-opcode reporting enabled.
    // The registers load only at the end of EXEC, so they hold the last
    // completed values through IDLE and into the next operation. An illegal
    // opcode overrides the ALU default and clears zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            result   <= 32'd0;
            negative <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            illop    <= 1'b0;
        end else if (state == EXEC) begin
            if (op_illegal) begin
                result   <= 32'd0;
                negative <= 1'b0;
                overflow <= 1'b0;
                zero     <= 1'b0;
                illop    <= 1'b1;
            end else begin
                result   <= alu_result;
                negative <= alu_negative;
                overflow <= alu_overflow;
                zero     <= alu_zero;
                illop    <= 1'b0;
            end
        end
    end
`else
    // ------------------------------------------------------------------------
    // Result and flag registers, illegal-opcode reporting disabled.
    // Illegal opcodes show the ALU default, and illop stays low.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            result   <= 32'd0;
            negative <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == EXEC) begin
            result   <= alu_result;
            negative <= alu_negative;
            overflow <= alu_overflow;
            zero     <= alu_zero;
        end
    end

    assign illop = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for alu_arbiter. Directed scenarios come first, then a
// randomized two-requester traffic phase. Expected outputs come from a
// transaction-level reference: each grant is an event that completes two
// cycles later. The expected result is computed arithmetically from the
// opcode definitions.
// Inputs are driven on the falling edge, and outputs are compared on the
// following falling edge.
// ============================================================================
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int FIRST_PRIO = 0;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req0;
    logic [3:0]  aluop0;
    logic [31:0] porta0;
    logic [31:0] portb0;
    logic        req1;
    logic [3:0]  aluop1;
    logic [31:0] porta1;
    logic [31:0] portb1;
    logic        done0;
    logic        done1;
    logic [31:0] result;
    logic        negative;
    logic        overflow;
    logic        zero;
    logic        illop;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: one in-flight transaction plus the visible registers.
    bit          m_pending;
    int          m_remaining;
    bit          m_owner;
    bit          m_last;
    logic [31:0] p_res;
    logic        p_neg;
    logic        p_ovf;
    logic        p_zero;
    logic        p_ill;
    logic [31:0] m_res;
    logic        m_neg;
    logic        m_ovf;
    logic        m_zero;
    logic        m_ill;
    bit          exp_done0;
    bit          exp_done1;
    bit          exp_busy;

    alu_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .req0     (req0),
        .aluop0   (aluop0),
        .porta0   (porta0),
        .portb0   (portb0),
        .req1     (req1),
        .aluop1   (aluop1),
        .porta1   (porta1),
        .portb1   (portb1),
        .done0    (done0),
        .done1    (done1),
        .result   (result),
        .negative (negative),
        .overflow (overflow),
        .zero     (zero),
        .illop    (illop),
        .busy     (busy)
    );

    // Free-running clock, 10 ns period.
    always #5 CLK = ~CLK;

    // Arithmetic definition of each opcode.
    function automatic void refAlu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic n, output logic o,
                                   output logic z, output logic il);
        longint sum;
        r  = 32'd0;
        o  = 1'b0;
        il = 1'b0;
        case (op)
            4'd0: r = a << (b % 32);
            4'd1: r = a >> (b % 32);
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: begin
                sum = longint'(a) + longint'(b);
                r   = sum[31:0];
                o   = (sum >= 64'sh1_0000_0000);
            end
            4'd7: begin
                r = a - b;
                o = (a < b);
            end
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: begin
                r = 32'd0;
`ifdef ALU_ARB_ILLOP_EN
                il = 1'b1;
`endif
            end
        endcase
        n = r[31];
        z = (r == 32'd0) && !il;
    endfunction

    function automatic logic [31:0] randWord();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0001;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] randOp();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Compare all DUT outputs against the reference for the current cycle.
    task automatic checkOutput();
        exp_done0 = 1'b0;
        exp_done1 = 1'b0;
        if (m_pending && m_remaining == 0) begin
            exp_done0 = !m_owner;
            exp_done1 = m_owner;
            m_res  = p_res;
            m_neg  = p_neg;
            m_ovf  = p_ovf;
            m_zero = p_zero;
            m_ill  = p_ill;
        end
        exp_busy = m_pending;
        checkValue("done0",    {31'd0, done0},    {31'd0, exp_done0});
        checkValue("done1",    {31'd0, done1},    {31'd0, exp_done1});
        checkValue("busy",     {31'd0, busy},     {31'd0, exp_busy});
        checkValue("result",   result,            m_res);
        checkValue("negative", {31'd0, negative}, {31'd0, m_neg});
        checkValue("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        checkValue("zero",     {31'd0, zero},     {31'd0, m_zero});
        checkValue("illop",    {31'd0, illop},    {31'd0, m_ill});
    endtask

    // Advance the reference with the inputs now on the pins, let the edge
    // happen, then check the outputs of the new cycle.
    task automatic applyStimulus();
        if (!nRST) begin
            m_pending = 1'b0;
            m_last    = (FIRST_PRIO == 0);
            m_res     = 32'd0;
            m_neg     = 1'b0;
            m_ovf     = 1'b0;
            m_zero    = 1'b0;
            m_ill     = 1'b0;
        end else if (m_pending) begin
            if (m_remaining == 0) m_pending = 1'b0;
            else m_remaining--;
        end else if (req0 || req1) begin
            m_owner = (req0 && req1) ? !m_last : req1;
            m_last  = m_owner;
            if (m_owner) refAlu(aluop1, porta1, portb1, p_res, p_neg, p_ovf, p_zero, p_ill);
            else refAlu(aluop0, porta0, portb0, p_res, p_neg, p_ovf, p_zero, p_ill);
            m_pending   = 1'b1;
            m_remaining = 1;
        end
        @(negedge CLK);
        checkOutput();
    endtask

    initial begin
        nRST = 1'b0;
        req0 = 1'b0; aluop0 = 4'd0; porta0 = 32'd0; portb0 = 32'd0;
        req1 = 1'b0; aluop1 = 4'd0; porta1 = 32'd0; portb1 = 32'd0;
        applyStimulus();
        applyStimulus();
        checkValue("reset_busy", {31'd0, busy}, 32'd0);
        nRST = 1'b1;
        applyStimulus();

        // ADD with carry-out: 0xFFFFFFFF + 1
        $display("[TB] ADD carry test");
        req0 = 1'b1; aluop0 = 4'd6; porta0 = 32'hFFFF_FFFF; portb0 = 32'd1;
        applyStimulus();
        applyStimulus();
        checkValue("add_done0",    {31'd0, done0},    32'd1);
        checkValue("add_result",   result,            32'd0);
        checkValue("add_zero",     {31'd0, zero},     32'd1);
        checkValue("add_overflow", {31'd0, overflow}, 32'd1);
        checkValue("add_negative", {31'd0, negative}, 32'd0);
        req0 = 1'b0;
        applyStimulus();

        // SUB with borrow on port 1, then signed compare
        $display("[TB] SUB / SLT test");
        req1 = 1'b1; aluop1 = 4'd7; porta1 = 32'd5; portb1 = 32'd7;
        applyStimulus();
        applyStimulus();
        checkValue("sub_done1",    {31'd0, done1},    32'd1);
        checkValue("sub_result",   result,            32'hFFFF_FFFE);
        checkValue("sub_negative", {31'd0, negative}, 32'd1);
        checkValue("sub_overflow", {31'd0, overflow}, 32'd1);
        req1 = 1'b0;
        applyStimulus();
        req1 = 1'b1; aluop1 = 4'd8; porta1 = 32'hFFFF_FFFF; portb1 = 32'd1;
        applyStimulus();
        applyStimulus();
        checkValue("slt_result", result, 32'd1);
        req1 = 1'b0;
        applyStimulus();

        // Operand change after grant must not affect the in-flight op
        $display("[TB] operand isolation test");
        req0 = 1'b1; aluop0 = 4'd6; porta0 = 32'd10; portb0 = 32'd20;
        applyStimulus();
        porta0 = 32'd1000; portb0 = 32'd5; aluop0 = 4'd7;
        applyStimulus();
        checkValue("iso_result", result, 32'd30);
        req0 = 1'b0;
        applyStimulus();

        // Reset during EXEC discards the op; the reissued request completes normally
        $display("[TB] reset during EXEC test");
        req0 = 1'b1; aluop0 = 4'd6; porta0 = 32'd3; portb0 = 32'd4;
        applyStimulus();
        req0 = 1'b0; nRST = 1'b0;
        applyStimulus();
        checkValue("rst_done0",  {31'd0, done0}, 32'd0);
        checkValue("rst_result", result,         32'd0);
        nRST = 1'b1;
        req0 = 1'b1; aluop0 = 4'd6; porta0 = 32'd1; portb0 = 32'd2;
        applyStimulus();
        applyStimulus();
        checkValue("reissue_done0",  {31'd0, done0}, 32'd1);
        checkValue("reissue_result", result,         32'd3);
        req0 = 1'b0;
        applyStimulus();

        // Illegal opcode 4'hC
        $display("[TB] illegal opcode test");
        req0 = 1'b1; aluop0 = 4'hC; porta0 = 32'd5; portb0 = 32'd6;
        applyStimulus();
        applyStimulus();
        checkValue("ill_done0",  {31'd0, done0}, 32'd1);
        checkValue("ill_result", result,         32'd0);
`ifdef ALU_ARB_ILLOP_EN
        checkValue("ill_illop", {31'd0, illop}, 32'd1);
        checkValue("ill_zero",  {31'd0, zero},  32'd0);
`else
        checkValue("ill_illop", {31'd0, illop}, 32'd0);
        checkValue("ill_zero",  {31'd0, zero},  32'd1);
`endif
        req0 = 1'b0;
        applyStimulus();

        // Both ports held from reset: done0 at cycle 2, done1 at 5, done0 at 8
        $display("[TB] round-robin from reset test");
        nRST = 1'b0;
        req0 = 1'b1; aluop0 = 4'd6; porta0 = 32'd1; portb0 = 32'd1;
        req1 = 1'b1; aluop1 = 4'd7; porta1 = 32'd9; portb1 = 32'd4;
        applyStimulus();
        nRST = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (i == 1) begin
                checkValue("rr_c2_done0", {31'd0, done0}, 32'd1);
                checkValue("rr_c2_result", result, 32'd2);
            end
            if (i == 4) begin
                checkValue("rr_c5_done1", {31'd0, done1}, 32'd1);
                checkValue("rr_c5_result", result, 32'd5);
            end
            if (i == 7) checkValue("rr_c8_done0", {31'd0, done0}, 32'd1);
        end
        req0 = 1'b0; req1 = 1'b0;
        applyStimulus();

        // Randomized traffic from two independent requesters
        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            nRST = ($urandom_range(0, 249) != 0);
            if (exp_done0) begin
                req0 = 1'b0;
            end else if (!req0) begin
                if ($urandom_range(0, 1) == 1) begin
                    req0 = 1'b1; aluop0 = randOp(); porta0 = randWord(); portb0 = randWord();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                aluop0 = randOp(); porta0 = randWord(); portb0 = randWord();
            end
            if (exp_done1) begin
                req1 = 1'b0;
            end else if (!req1) begin
                if ($urandom_range(0, 1) == 1) begin
                    req1 = 1'b1; aluop1 = randOp(); porta1 = randWord(); portb1 = randWord();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                aluop1 = randOp(); porta1 = randWord(); portb1 = randWord();
            end
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
